fetch_unit: RTL and testbench

Instruction fetch stage of the pipelined CPU. Holds the PC and issues word fetches to a synchronous instruction memory with one-cycle read latency. Buffers returned instructions in a 2-entry queue and presents them to decode over a valid/ready handshake. Handles pipeline redirects (branch/jump resolution) by flushing everything in flight.

---
 rtl/fetch_unit_if.sv | 24 ++
 rtl/fetch_unit.sv | 136 +++++++++++++
 tb/tb_fetch_unit.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect input, decode handshake.
// master = fetch_unit side, slave = memory/decode/branch-resolution side.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_pred_taken;

    modport master (
        output imem_req, imem_addr, id_valid, id_pc, id_instr, id_pred_taken,
        input  imem_rdata, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_pc, id_instr, id_pred_taken,
        output imem_rdata, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, one-deep in-flight tracking, 2-entry instruction queue to decode.
// Optional JAL prediction in fetch is enabled by defining FETCH_JAL_PREDICT_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    logic [31:0] pc_reg;
    logic        inflight_reg;
    logic        kill_reg;
    logic [31:0] inflight_pc_reg;
    logic [1:0]  count_reg;
    logic        rd_ptr_reg;
    logic        wr_ptr_reg;

    logic [31:0] slot_pc    [2];
    logic [31:0] slot_instr [2];
    logic        slot_pred  [2];

    logic        pop;
    logic        push;
    logic        req;
    logic [2:0]  occupancy;
    logic        jal_hit;
    logic [31:0] jal_target;
    logic        unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

    assign bus.id_valid = (count_reg != 2'd0);
    assign pop          = bus.id_valid & bus.id_ready;

    // Slots already committed (queued + returning) after this cycle's pop; a killed
    // response still counts, which keeps the queue from ever overflowing.
    assign occupancy = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
    assign req       = !rst && !bus.redirect_valid && (occupancy < 3'd2);
    assign push      = inflight_reg && !kill_reg && !bus.redirect_valid;

    assign bus.imem_req  = req;
    assign bus.imem_addr = rst ? 32'h0 : pc_reg;

`ifdef FETCH_JAL_PREDICT_EN
    logic [31:0] jal_imm;
    assign jal_imm    = {{11{bus.imem_rdata[31]}}, bus.imem_rdata[31], bus.imem_rdata[19:12],
                         bus.imem_rdata[20], bus.imem_rdata[30:21], 1'b0};
    assign jal_hit    = push && (bus.imem_rdata[6:0] == 7'b1101111);
    assign jal_target = inflight_pc_reg + jal_imm;
`else
    assign jal_hit    = 1'b0;
    assign jal_target = 32'h0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg          <= RESET_PC;
            inflight_reg    <= 1'b0;
            kill_reg        <= 1'b0;
            inflight_pc_reg <= 32'h0;
            count_reg       <= 2'd0;
            rd_ptr_reg      <= 1'b0;
            wr_ptr_reg      <= 1'b0;
        end else begin
            inflight_reg    <= req;
            inflight_pc_reg <= pc_reg;
            // A predicted-taken JAL squashes the sequential fetch issued alongside it.
            kill_reg        <= req && jal_hit;
            if (bus.redirect_valid) begin
                pc_reg     <= {bus.redirect_pc[31:2], 2'b00};
                count_reg  <= 2'd0;
                rd_ptr_reg <= 1'b0;
                wr_ptr_reg <= 1'b0;
            end else begin
                if (jal_hit) begin
                    pc_reg <= jal_target;
                end else if (req) begin
                    pc_reg <= pc_reg + 32'd4;
                end
                count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
                if (push) begin
                    wr_ptr_reg <= ~wr_ptr_reg;
                end
                if (pop) begin
                    rd_ptr_reg <= ~rd_ptr_reg;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [31:0] entry_pc_reg;
            logic [31:0] entry_instr_reg;
            logic        entry_wr;

            assign entry_wr = push && (wr_ptr_reg == 1'(gi));

            always_ff @(posedge clk) begin
                if (entry_wr) begin
                    entry_pc_reg    <= inflight_pc_reg;
                    entry_instr_reg <= bus.imem_rdata;
                end
            end

            assign slot_pc[gi]    = entry_pc_reg;
            assign slot_instr[gi] = entry_instr_reg;

`ifdef FETCH_JAL_PREDICT_EN
            logic entry_pred_reg;
            always_ff @(posedge clk) begin
                if (entry_wr) begin
                    entry_pred_reg <= jal_hit;
                end
            end
            assign slot_pred[gi] = entry_pred_reg;
`else
            assign slot_pred[gi] = 1'b0;
`endif
        end
    endgenerate

    // Payload is forced to zero whenever nothing valid is presented (reset, flush, empty).
    assign bus.id_pc    = bus.id_valid ? slot_pc[rd_ptr_reg]    : 32'h0;
    assign bus.id_instr = bus.id_valid ? slot_instr[rd_ptr_reg] : 32'h0;
`ifdef FETCH_JAL_PREDICT_EN
    assign bus.id_pred_taken = bus.id_valid && slot_pred[rd_ptr_reg];
`else
    logic unused_slot_pred;
    assign unused_slot_pred  = slot_pred[0] ^ slot_pred[1];
    assign bus.id_pred_taken = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed timing checks plus a randomized run scored
// against a program-order stream model of what decode should receive.
module tb_fetch_unit;

`ifdef FETCH_JAL_PREDICT_EN
    localparam bit JAL_EN = 1'b1;
`else
    localparam bit JAL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_unit_if bus ();
    fetch_unit_if wbus ();

    fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (wbus)
    );

    int          tests = 0;
    int          fails = 0;
    bit          jal_mode = 1'b0;
    logic [31:0] exp_pc;
    bit          hold;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;
    logic        hold_pred;
    logic [31:0] popped_q[$];

    // Memory contents: each word holds its own address, except a JAL +16 at address 8.
    function automatic logic [31:0] memf(input logic [31:0] a, input bit jm);
        return (jm && a == 32'd8) ? 32'h0100_006F : a;
    endfunction

    function automatic logic [31:0] jimm(input logic [31:0] i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    always @(posedge clk) if (bus.imem_req)  bus.imem_rdata  <= memf(bus.imem_addr, jal_mode);
    always @(posedge clk) if (wbus.imem_req) wbus.imem_rdata <= wbus.imem_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Sample the current cycle and score it against the stream model.
    task automatic sample();
        logic [31:0] ei;
        bit          ep;
        #1;
        if (rst) begin
            check("rst_imem_req", 32'(bus.imem_req), 32'd0);
            check("rst_imem_addr", bus.imem_addr, 32'd0);
            check("rst_id_valid", 32'(bus.id_valid), 32'd0);
            check("rst_id_pc", bus.id_pc, 32'd0);
            check("rst_id_instr", bus.id_instr, 32'd0);
            check("rst_id_pred", 32'(bus.id_pred_taken), 32'd0);
            exp_pc = 32'h0;
            hold   = 1'b0;
        end else begin
            if (hold) begin
                check("hold_valid", 32'(bus.id_valid), 32'd1);
                check("hold_pc", bus.id_pc, hold_pc);
                check("hold_instr", bus.id_instr, hold_instr);
                check("hold_pred", 32'(bus.id_pred_taken), 32'(hold_pred));
            end
            if (bus.imem_req) check("addr_align", 32'(bus.imem_addr[1:0]), 32'd0);
            if (bus.id_valid && bus.id_ready) begin
                ei = memf(exp_pc, jal_mode);
                ep = JAL_EN && (ei[6:0] == 7'b1101111);
                check("pop_pc", bus.id_pc, exp_pc);
                check("pop_instr", bus.id_instr, ei);
                check("pop_pred", 32'(bus.id_pred_taken), 32'(ep));
                $display("[TB] pop pc=%h instr=%h pred=%0d", bus.id_pc, bus.id_instr, bus.id_pred_taken);
                popped_q.push_back(bus.id_pc);
                exp_pc = ep ? exp_pc + jimm(ei) : exp_pc + 32'd4;
            end
            if (bus.redirect_valid) begin
                check("redirect_no_req", 32'(bus.imem_req), 32'd0);
                exp_pc = {bus.redirect_pc[31:2], 2'b00};
            end
            hold       = bus.id_valid && !bus.id_ready && !bus.redirect_valid;
            hold_pc    = bus.id_pc;
            hold_instr = bus.id_instr;
            hold_pred  = bus.id_pred_taken;
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic cycle();
        sample();
        tick();
    endtask

    task automatic do_reset(input bit ready);
        rst = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.id_ready = ready;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int n12;
        bit got;
        rst = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = 32'h0;
        bus.id_ready        = 1'b1;
        wbus.redirect_valid = 1'b0;
        wbus.redirect_pc    = 32'h0;
        wbus.id_ready       = 1'b1;
        #1 rst = 1'b1;
        tick();

        // Sequential fetch, latency and PC wrap on the second instance.
        do_reset(1'b1);
        for (int k = 0; k < 10; k++) begin
            sample();
            check("seq_req", 32'(bus.imem_req), 32'd1);
            check("seq_addr", bus.imem_addr, 32'(4 * k));
            check("seq_valid", 32'(bus.id_valid), 32'(k >= 2));
            if (k >= 2) check("seq_id_pc", bus.id_pc, 32'(4 * (k - 2)));
            if (k < 3) check("wrap_addr", wbus.imem_addr, 32'hFFFF_FFF8 + 32'(4 * k));
            tick();
        end

        // Backpressure: queue fills, requests stop, order preserved on release.
        do_reset(1'b0);
        for (int k = 0; k < 7; k++) begin
            sample();
            if (k >= 2) begin
                check("bp_valid", 32'(bus.id_valid), 32'd1);
                check("bp_id_pc", bus.id_pc, 32'd0);
            end
            if (k >= 3) check("bp_no_req", 32'(bus.imem_req), 32'd0);
            tick();
        end
        bus.id_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sample();
            check("bp_release_pc", bus.id_pc, 32'(4 * k));
            tick();
        end

        // Redirect with an entry buffered and a response in flight.
        do_reset(1'b0);
        cycle();
        cycle();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0103;
        cycle();
        bus.redirect_valid = 1'b0;
        sample();
        check("rd_flush_valid", 32'(bus.id_valid), 32'd0);
        check("rd_req", 32'(bus.imem_req), 32'd1);
        check("rd_addr", bus.imem_addr, 32'h100);
        tick();
        sample();
        check("rd_valid_r2", 32'(bus.id_valid), 32'd0);
        tick();
        sample();
        check("rd_valid_r3", 32'(bus.id_valid), 32'd1);
        check("rd_first_pc", bus.id_pc, 32'h100);
        tick();
        // Back-to-back redirects: the second wins.
        bus.id_ready = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        cycle();
        bus.redirect_pc    = 32'h300;
        cycle();
        bus.redirect_valid = 1'b0;
        sample();
        check("b2b_addr", bus.imem_addr, 32'h300);
        tick();
        cycle();
        sample();
        check("b2b_valid", 32'(bus.id_valid), 32'd1);
        check("b2b_pc", bus.id_pc, 32'h300);
        tick();

        // Reset mid-fetch: stale response must be dropped.
        for (int k = 0; k < 4; k++) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sample();
            check("rr_addr", bus.imem_addr, 32'(4 * k));
            check("rr_valid", 32'(bus.id_valid), 32'(k >= 2));
            if (k == 2) begin
                check("rr_pc", bus.id_pc, 32'd0);
                check("rr_instr", bus.id_instr, 32'd0);
            end
            tick();
        end

        // JAL at address 8.
        jal_mode = 1'b1;
        do_reset(1'b1);
        popped_q.delete();
        for (int k = 0; k < 12; k++) cycle();
        check("jal_q_len", 32'(popped_q.size() >= 5), 32'd1);
        if (popped_q.size() >= 5) begin
            check("jal_pc8", popped_q[2], 32'd8);
            check("jal_next", popped_q[3], JAL_EN ? 32'd24 : 32'd12);
        end
        n12 = 0;
        foreach (popped_q[i]) if (popped_q[i] == 32'd12) n12++;
        check("jal_pc12_count", 32'(n12), JAL_EN ? 32'd0 : 32'd1);
        jal_mode = 1'b0;

        // Randomized run against the stream model.
        do_reset(1'b1);
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(99) == 0) begin
                bus.redirect_valid = 1'b0;
                rst = 1'b1;
                cycle();
                rst = 1'b0;
            end else begin
                bus.id_ready       = ($urandom_range(9) < 7);
                bus.redirect_valid = ($urandom_range(19) == 0);
                bus.redirect_pc    = $urandom;
                cycle();
            end
        end

        // Drain: the stream must keep flowing.
        bus.redirect_valid = 1'b0;
        bus.id_ready = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            sample();
            if (bus.id_valid) got = 1'b1;
            tick();
        end
        check("drain_valid", 32'(got), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
